// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and constants for the UART transmit buffer and its FIFO.
// The drain FSM states live here so that other blocks on the same link can decode them.
package uart_tx_buffer_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    TXB_IDLE,
    TXB_START,
    TXB_BUSY,
    TXB_GAP
  } txb_state_t;

  function automatic int unsigned fifo_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Start/active/done link between a byte source and uart_tx.
// The master launches bytes with a one-cycle start; the slave reports active and done.
interface uart_tx_buffer_if
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_BYTE_W
) ();

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_start;
  logic                  tx_active;
  logic                  tx_done;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_active,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_active,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Single-clock byte FIFO with occupancy count and synchronous clear.
// A push is accepted when full only if a pop happens in the same cycle.
module uart_tx_buffer_sync_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_BYTE_W,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  push_ok,
  output logic                  pop_ok
);

  localparam int unsigned Depth = fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Clear wins over both ports so a flushed FIFO is really empty afterwards.
  assign pop_ok  = pop && !empty && !clear;
  assign push_ok = push && !clear && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FullCount);

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus drain engine feeding uart_tx over the start/active/done link.
// Handlers push at full clock rate; the FSM launches one byte per UART frame.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_BYTE_W,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_50mhz,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  idle,
  uart_tx_buffer_if.master      tx
);

  txb_state_t            state_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_start_q;
  logic                  overflow_q;

  logic                  push;
  logic                  pop;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head;

  // A write coinciding with flush is discarded, and flush also holds off a launch.
  assign push = wr_en && !flush;
  assign pop  = (state_q == TXB_IDLE) && !tx.tx_active && !flush;

  uart_tx_buffer_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk_50mhz),
    .rst_n     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .clear     (flush),
    .head      (head),
    .full      (full),
    .empty     (fifo_empty),
    .count     (count),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok)
  );

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (flush) begin
      overflow_q <= 1'b0;
    end else if (push && !push_ok) begin
      overflow_q <= 1'b1;
    end
  end

  // The frame already handed to uart_tx always runs to tx_done, even across a flush.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q    <= TXB_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        TXB_IDLE: begin
          if (pop_ok) begin
            tx_data_q  <= head;
            tx_start_q <= 1'b1;
            state_q    <= TXB_START;
          end
        end
        TXB_START: begin
          state_q <= TXB_BUSY;
        end
        TXB_BUSY: begin
          if (tx.tx_done) begin
            state_q <= TXB_GAP;
          end
        end
        TXB_GAP: begin
          state_q <= TXB_IDLE;
        end
        default: begin
          state_q <= TXB_IDLE;
        end
      endcase
    end
  end

  assign empty       = fifo_empty;
  assign overflow    = overflow_q;
  assign idle        = fifo_empty && (state_q == TXB_IDLE);
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_start = tx_start_q;

  a_start_in_start: assert property (@(posedge clk_50mhz) disable iff (!reset)
    tx_start_q |-> (state_q == TXB_START));

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: FIFO vector table plus drain-engine sequences
// against a simple uart_tx responder model.
module tb_uart_tx_buffer;

  logic       clk_50mhz = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       idle;

  logic hold_active;
  logic model_active;
  logic model_done;
  logic stray_done;
  int   lat;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];

  always #10 clk_50mhz = ~clk_50mhz;

  uart_tx_buffer_if #(.DATA_WIDTH(8)) bus ();

  assign bus.tx_active = model_active | hold_active;
  assign bus.tx_done   = model_done | stray_done;

  uart_tx_buffer #(
    .DATA_WIDTH (8),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .idle      (idle),
    .tx        (bus)
  );

  // uart_tx responder: active for lat cycles after start, then a one-cycle done.
  initial begin
    model_active = 1'b0;
    model_done   = 1'b0;
    forever begin
      @(negedge clk_50mhz);
      if (bus.tx_start) begin
        rx_q.push_back(bus.tx_data);
        model_active = 1'b1;
        repeat (lat) @(negedge clk_50mhz);
        model_active = 1'b0;
        model_done   = 1'b1;
        @(negedge clk_50mhz);
        model_done = 1'b0;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
    logic       exp_idle;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return {24'd0, rx_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic add_vec(input logic w, input logic [7:0] d, input logic f, input int c,
                         input logic fu, input logic em, input logic ov, input logic id,
                         input string name);
    vec_t v;
    v.wr_en = w; v.wr_data = d; v.flush = f; v.exp_count = c;
    v.exp_full = fu; v.exp_empty = em; v.exp_ovf = ov; v.exp_idle = id; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    reset   = 1'b0;
    repeat (3) @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    reset = 1'b1;
    rx_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk_50mhz);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk_50mhz);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk_50mhz);
      k++;
    end
    check(name, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!idle && k < budget) begin
      @(negedge clk_50mhz);
      k++;
    end
    check(name, {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_model_active(input int budget, input string name);
    int k = 0;
    while (!model_active && k < budget) begin
      @(posedge clk_50mhz);
      k++;
    end
    check(name, {31'd0, model_active}, 32'd1);
  endtask

  initial begin
    int k;
    hold_active = 1'b1;
    stray_done  = 1'b0;
    lat         = 4;
    reset       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    flush       = 1'b0;

    // FIFO-only vectors: tx_active held high so the drain engine never pops.
    add_vec(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, "nop");
    add_vec(1'b1, 8'h10, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, "push1");
    add_vec(1'b1, 8'h11, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, "push2");
    add_vec(1'b1, 8'h12, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, "flush_with_wr");
    for (int i = 0; i < 16; i++) begin
      add_vec(1'b1, 8'(i), 1'b0, i + 1, (i == 15), 1'b0, 1'b0, 1'b0,
              $sformatf("fill%0d", i));
    end
    add_vec(1'b1, 8'hAA, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, "drop_when_full");
    add_vec(1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, "overflow_sticky");
    add_vec(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, "flush_clears");
    add_vec(1'b1, 8'h5A, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, "push_after_flush");
    add_vec(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, "flush_again");

    // Reset state, sampled while reset is still asserted.
    #5;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_idle", idle, 1);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    do_reset();

    foreach (vecs[i]) begin
      @(negedge clk_50mhz);
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      flush   = vecs[i].flush;
      @(posedge clk_50mhz);
      #1;
      check({vecs[i].name, "_count"}, count, vecs[i].exp_count);
      check({vecs[i].name, "_full"}, full, vecs[i].exp_full);
      check({vecs[i].name, "_empty"}, empty, vecs[i].exp_empty);
      check({vecs[i].name, "_overflow"}, overflow, vecs[i].exp_ovf);
      check({vecs[i].name, "_idle"}, idle, vecs[i].exp_idle);
    end
    wr_en = 1'b0;
    flush = 1'b0;

    // 1: single byte latency, long frame, idle after GAP.
    hold_active = 1'b0;
    lat = 100;
    do_reset();
    push_byte(8'h41);
    check("t1_count_after_push", count, 1);
    check("t1_no_start_yet", bus.tx_start, 0);
    @(posedge clk_50mhz);
    #1;
    check("t1_start", bus.tx_start, 1);
    check("t1_data", bus.tx_data, 8'h41);
    check("t1_popped", count, 0);
    @(posedge clk_50mhz);
    #1;
    check("t1_start_pulse_end", bus.tx_start, 0);
    check("t1_data_hold", bus.tx_data, 8'h41);
    k = 0;
    while (!model_done && k < 200) begin
      @(posedge clk_50mhz);
      k++;
    end
    check("t1_done_seen", model_done, 1);
    @(negedge clk_50mhz);
    check("t1_gap_not_idle", idle, 0);
    @(negedge clk_50mhz);
    check("t1_idle_after_gap", idle, 1);
    check("t1_rx_byte", rx_at(0), 8'h41);

    // 2: 16 bytes back to back while the line is owned elsewhere, then drained in order.
    lat = 4;
    hold_active = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("t2_full", full, 1);
    check("t2_count16", count, 16);
    hold_active = 1'b0;
    wait_rx(16, 400, "t2_rx_count");
    for (int i = 0; i < 16; i++) check($sformatf("t2_rx%0d", i), rx_at(i), i);
    wait_idle(50, "t2_idle");
    check("t2_no_overflow", overflow, 0);

    // 3: engine busy on a long frame, fill to 16, extra byte dropped.
    lat = 40;
    do_reset();
    push_byte(8'hC0);
    wait_model_active(20, "t3_busy");
    lat = 4;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    push_byte(8'hAA);
    check("t3_overflow", overflow, 1);
    check("t3_count16", count, 16);
    check("t3_full", full, 1);
    wait_rx(17, 800, "t3_rx_count");
    check("t3_rx_first", rx_at(0), 8'hC0);
    for (int i = 0; i < 16; i++) check($sformatf("t3_rx%0d", i + 1), rx_at(i + 1), i);
    wait_idle(50, "t3_idle");
    check("t3_overflow_sticky", overflow, 1);

    // 4: full FIFO, pop and push on the same edge -> accepted, count unchanged.
    hold_active = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    check("t4_full_before", full, 1);
    @(negedge clk_50mhz);
    hold_active = 1'b0;
    wr_en       = 1'b1;
    wr_data     = 8'h55;
    @(posedge clk_50mhz);
    #1;
    wr_en = 1'b0;
    check("t4_count_held", count, 16);
    check("t4_no_overflow", overflow, 0);
    check("t4_start", bus.tx_start, 1);
    check("t4_first_data", bus.tx_data, 8'h20);
    wait_rx(17, 400, "t4_rx_count");
    for (int i = 0; i < 16; i++) check($sformatf("t4_rx%0d", i), rx_at(i), 8'h20 + i);
    check("t4_rx_last", rx_at(16), 8'h55);
    wait_idle(50, "t4_idle");

    // 5: flush during BUSY of the first of five bytes; the in-flight byte completes.
    hold_active = 1'b1;
    lat = 20;
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'h31 + 8'(i));
    hold_active = 1'b0;
    wait_model_active(20, "t5_busy");
    @(negedge clk_50mhz);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    @(posedge clk_50mhz);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
    check("t5_count0", count, 0);
    check("t5_empty", empty, 1);
    check("t5_overflow0", overflow, 0);
    check("t5_inflight_not_idle", idle, 0);
    wait_idle(100, "t5_idle");
    repeat (10) @(posedge clk_50mhz);
    check("t5_rx_count", rx_q.size(), 1);
    check("t5_rx_byte", rx_at(0), 8'h31);

    // 6: reset asserted mid-frame, then a stray done must not launch anything.
    lat = 30;
    do_reset();
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    wait_model_active(20, "t6_busy");
    @(negedge clk_50mhz);
    #2;
    check("t6_count_before", count, 2);
    check("t6_busy_not_idle", idle, 0);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_tx_start", bus.tx_start, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_count", count, 0);
    check("t6_rst_idle", idle, 1);
    check("t6_rst_tx_data", bus.tx_data, 0);
    repeat (2) @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    reset = 1'b1;
    repeat (40) @(posedge clk_50mhz);
    check("t6_rx_after_model_done", rx_q.size(), 1);
    @(negedge clk_50mhz);
    stray_done = 1'b1;
    @(negedge clk_50mhz);
    stray_done = 1'b0;
    repeat (5) @(posedge clk_50mhz);
    #1;
    check("t6_stray_no_start", bus.tx_start, 0);
    check("t6_stray_rx", rx_q.size(), 1);
    check("t6_stray_idle", idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
